// File: rtl/avalon_bus_arbiter_if.sv
// One Avalon-MM link: a requester drives command/data and the responder returns
// readdata and waitrequest.
interface avalon_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin or fixed priority,
// per-master completed-transfer counters and a sticky protocol-error flag.
//
// Handshake: a master request (read|write) is held until the arbiter returns
// waitrequest=0 for it; the transfer completes on the rising edge where the
// granted master is requesting and the slave's waitrequest is 0.
module avalon_bus_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant,
  output logic [CNT_W-1:0]     xfer_count0,
  output logic [CNT_W-1:0]     xfer_count1,
  output logic                 protocol_error,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_grant;
  logic       req0, req1;
  logic       both0, both1;
  logic       done0, done1;
  logic       drop0, drop1;

  assign req0  = m0.read | m0.write;
  assign req1  = m1.read | m1.write;
  assign both0 = m0.read & m0.write;
  assign both1 = m1.read & m1.write;

  assign done0 = (state == ST_GRANT0) && req0 && !s.waitrequest;
  assign done1 = (state == ST_GRANT1) && req1 && !s.waitrequest;
  assign drop0 = (state == ST_GRANT0) && !req0;
  assign drop1 = (state == ST_GRANT1) && !req1;

  assign state_dbg   = state;
  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          // last_grant=1 means m1 was served last, so m0 takes the tie
          state_nxt = ((FIXED_PRIORITY != 0) || last_grant) ? ST_GRANT0 : ST_GRANT1;
        end else if (req0) begin
          state_nxt = ST_GRANT0;
        end else if (req1) begin
          state_nxt = ST_GRANT1;
        end
      end
      ST_GRANT0: if (!req0 || !s.waitrequest) state_nxt = ST_IDLE;
      ST_GRANT1: if (!req1 || !s.waitrequest) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s.address      = '0;
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.writedata    = '0;
    s.byteenable   = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    grant          = 2'b00;
    case (state)
      ST_GRANT0: begin
        s.address      = m0.address;
        s.read         = m0.read & ~m0.write;
        s.write        = m0.write & ~m0.read;
        s.writedata    = m0.writedata;
        s.byteenable   = m0.byteenable;
        m0.waitrequest = s.waitrequest;
        grant          = 2'b01;
      end
      ST_GRANT1: begin
        s.address      = m1.address;
        s.read         = m1.read & ~m1.write;
        s.write        = m1.write & ~m1.read;
        s.writedata    = m1.writedata;
        s.byteenable   = m1.byteenable;
        m1.waitrequest = s.waitrequest;
        grant          = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      xfer_count0    <= '0;
      xfer_count1    <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done0) begin
        last_grant  <= 1'b0;
        xfer_count0 <= xfer_count0 + CNT_W'(1);
      end
      if (done1) begin
        last_grant  <= 1'b1;
        xfer_count1 <= xfer_count1 + CNT_W'(1);
      end
      if (both0 || both1 || drop0 || drop1) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: a round-robin instance plus a fixed-priority
// instance (8-bit counters) fed with the same master and slave stimulus.
module tb_avalon_bus_arbiter;

  logic clk;
  logic reset;

  avalon_bus_arbiter_if m0_if ();
  avalon_bus_arbiter_if m1_if ();
  avalon_bus_arbiter_if s_if ();
  avalon_bus_arbiter_if f0_if ();
  avalon_bus_arbiter_if f1_if ();
  avalon_bus_arbiter_if fs_if ();

  logic [1:0]  grant_rr, grant_fp;
  logic [15:0] cnt0_rr, cnt1_rr;
  logic [7:0]  cnt0_fp, cnt1_fp;
  logic        err_rr, err_fp;
  logic [1:0]  state_rr, state_fp;

  avalon_bus_arbiter #(.FIXED_PRIORITY(0), .CNT_W(16)) u_rr (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant_rr), .xfer_count0(cnt0_rr), .xfer_count1(cnt1_rr),
    .protocol_error(err_rr), .state_dbg(state_rr)
  );

  avalon_bus_arbiter #(.FIXED_PRIORITY(1), .CNT_W(8)) u_fp (
    .clk(clk), .reset(reset), .m0(f0_if), .m1(f1_if), .s(fs_if),
    .grant(grant_fp), .xfer_count0(cnt0_fp), .xfer_count1(cnt1_fp),
    .protocol_error(err_fp), .state_dbg(state_fp)
  );

  // The fixed-priority instance mirrors the round-robin instance's inputs
  assign f0_if.address     = m0_if.address;
  assign f0_if.read        = m0_if.read;
  assign f0_if.write       = m0_if.write;
  assign f0_if.writedata   = m0_if.writedata;
  assign f0_if.byteenable  = m0_if.byteenable;
  assign f1_if.address     = m1_if.address;
  assign f1_if.read        = m1_if.read;
  assign f1_if.write       = m1_if.write;
  assign f1_if.writedata   = m1_if.writedata;
  assign f1_if.byteenable  = m1_if.byteenable;
  assign fs_if.readdata    = s_if.readdata;
  assign fs_if.waitrequest = s_if.waitrequest;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt0 = 16'd0;
  logic [15:0] exp_cnt1 = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_master(input int m, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = addr;
      m0_if.writedata = wdata; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = addr;
      m1_if.writedata = wdata; m1_if.byteenable = be;
    end
  endtask

  // One transfer on the round-robin instance with the slave stalling 'waits' cycles
  task automatic do_xfer(input int m, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int waits, input logic [31:0] rdata);
    int          active;
    logic        done;
    logic [31:0] obs;
    logic [31:0] exp;
    @(negedge clk);
    s_if.waitrequest = 1'b1;
    s_if.readdata    = 32'h0;
    drive_master(m, !wr, wr, addr, wdata, be);
    exp_q.push_back(wr ? wdata : rdata);
    if (m == 0) exp_cnt0 = exp_cnt0 + 16'd1;
    else        exp_cnt1 = exp_cnt1 + 16'd1;
    @(negedge clk);
    check("grant_latency", {30'd0, grant_rr}, (m == 0) ? 32'd1 : 32'd2);
    active = 0;
    done   = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (s_if.read || s_if.write) active++;
      check("other_waitrequest", {31'd0, (m == 0) ? m1_if.waitrequest : m0_if.waitrequest}, 32'd1);
      if (c >= waits) begin
        s_if.waitrequest = 1'b0;
        s_if.readdata    = rdata;
        #1;
        obs = wr ? s_if.writedata : ((m == 0) ? m0_if.readdata : m1_if.readdata);
        exp = exp_q.pop_front();
        check("data", obs, exp);
        check("s_address", s_if.address, addr);
        check("s_byteenable", {28'd0, s_if.byteenable}, {28'd0, be});
        check("s_cmd", {30'd0, s_if.read, s_if.write}, {30'd0, !wr, wr});
        check("own_waitrequest", {31'd0, (m == 0) ? m0_if.waitrequest : m1_if.waitrequest}, 32'd0);
        done = 1'b1;
        @(negedge clk);
        drive_master(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        s_if.waitrequest = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    check("active_cycles", active, waits + 1);
    check("grant_idle", {30'd0, grant_rr}, 32'd0);
    check("count", (m == 0) ? {16'd0, cnt0_rr} : {16'd0, cnt1_rr},
          (m == 0) ? {16'd0, exp_cnt0} : {16'd0, exp_cnt1});
  endtask

  // ---------------- arbitration vectors ----------------
  typedef struct packed {
    logic       m0_req;
    logic       m1_req;
    logic       swait;
    logic [1:0] g_rr;
    logic [1:0] g_fp;
    logic       w0;
    logic       w1;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};

    reset = 1'b1;
    drive_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_if.waitrequest = 1'b1;
    s_if.readdata    = 32'h0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_grant", {30'd0, grant_rr}, 32'd0);
    check("rst_count0", {16'd0, cnt0_rr}, 32'd0);
    check("rst_count1", {16'd0, cnt1_rr}, 32'd0);
    check("rst_error", {31'd0, err_rr}, 32'd0);
    check("rst_s_cmd", {30'd0, s_if.read, s_if.write}, 32'd0);
    check("rst_waitrequest", {30'd0, m0_if.waitrequest, m1_if.waitrequest}, 32'd3);
    reset = 1'b0;

    // contention table, shared by both instances
    for (int i = 0; i < 13; i++) begin
      m0_if.read = vecs[i].m0_req;
      m1_if.read = vecs[i].m1_req;
      s_if.waitrequest = vecs[i].swait;
      @(negedge clk);
      check($sformatf("vec%0d_grant_rr", i), {30'd0, grant_rr}, {30'd0, vecs[i].g_rr});
      check($sformatf("vec%0d_grant_fp", i), {30'd0, grant_fp}, {30'd0, vecs[i].g_fp});
      check($sformatf("vec%0d_wait", i), {30'd0, m0_if.waitrequest, m1_if.waitrequest},
            {30'd0, vecs[i].w0, vecs[i].w1});
    end
    check("tbl_count0_rr", {16'd0, cnt0_rr}, 32'd3);
    check("tbl_count1_rr", {16'd0, cnt1_rr}, 32'd2);
    check("tbl_count0_fp", {24'd0, cnt0_fp}, 32'd4);
    check("tbl_count1_fp", {24'd0, cnt1_fp}, 32'd1);
    check("tbl_error", {31'd0, err_rr}, 32'd0);
    exp_cnt0 = 16'd3;
    exp_cnt1 = 16'd2;
    s_if.waitrequest = 1'b1;

    // directed transfers
    do_xfer(0, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 0, 32'h12345678);
    do_xfer(1, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'hF, 3, 32'h0);
    for (int i = 0; i < 6; i++) begin
      do_xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom);
    end
    check("pre_proto_error", {31'd0, err_rr}, 32'd0);

    // read and write together, then abandon while granted
    @(negedge clk);
    s_if.waitrequest = 1'b1;
    drive_master(0, 1'b1, 1'b1, 32'h40, 32'h55, 4'hF);
    @(negedge clk);
    check("proto_grant", {30'd0, grant_rr}, 32'd1);
    check("proto_s_cmd", {30'd0, s_if.read, s_if.write}, 32'd0);
    check("proto_error_set", {31'd0, err_rr}, 32'd1);
    @(negedge clk);
    check("proto_s_cmd_hold", {30'd0, s_if.read, s_if.write}, 32'd0);
    drive_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("proto_drop_idle", {30'd0, grant_rr}, 32'd0);
    check("proto_drop_count", {16'd0, cnt0_rr}, {16'd0, exp_cnt0});
    do_xfer(0, 1'b1, 32'h80, 32'hA5A5A5A5, 4'h3, 1, 32'h0);
    check("proto_error_sticky", {31'd0, err_rr}, 32'd1);

    // reset while m1 is stalled mid-write
    @(negedge clk);
    s_if.waitrequest = 1'b1;
    drive_master(1, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("rmid_grant", {30'd0, grant_rr}, 32'd2);
    check("rmid_s_write", {31'd0, s_if.write}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_idle", {30'd0, grant_rr}, 32'd0);
    check("rmid_s_write_off", {31'd0, s_if.write}, 32'd0);
    check("rmid_counts", {cnt0_rr, cnt1_rr}, 32'd0);
    check("rmid_error_clr", {31'd0, err_rr}, 32'd0);
    check("rmid_waitrequest", {30'd0, m0_if.waitrequest, m1_if.waitrequest}, 32'd3);
    drive_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    exp_cnt0 = 16'd0;
    exp_cnt1 = 16'd0;

    // back-to-back m0 reads through the 8-bit counter wrap
    @(negedge clk);
    s_if.waitrequest = 1'b0;
    drive_master(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    repeat (510) @(negedge clk);
    check("wrap_pre_fp", {24'd0, cnt0_fp}, 32'hFF);
    check("wrap_pre_rr", {16'd0, cnt0_rr}, 32'd255);
    repeat (2) @(negedge clk);
    check("wrap_fp", {24'd0, cnt0_fp}, 32'h0);
    check("wrap_rr", {16'd0, cnt0_rr}, 32'd256);
    drive_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("wrap_error", {30'd0, err_rr, err_fp}, 32'd0);
    check("wrap_idle", {30'd0, grant_rr}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
# avalon_bus_arbiter

Two-master to one-slave Avalon-MM arbiter that lets the `mips_cpu_bus` data path and a second requester (e.g. a RAM loader or DMA) share a single `RAM_8x_40000_avalon` instance. It serialises transfers, forwards the granted master's request to the slave, stalls the other master with `waitrequest`, and keeps per-master transfer counts and a sticky protocol-error flag for the bench.

## Interface
- `FIXED_PRIORITY`, default 0: 0 = round-robin between masters; 1 = m0 always wins contention.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `m0_address`, `m1_address` input 32: master byte address.
- `m0_read`, `m1_read` input 1: read request, held until accepted.
- `m0_write`, `m1_write` input 1: write request, held until accepted.
- `m0_writedata`, `m1_writedata` input 32: write data.
- `m0_byteenable`, `m1_byteenable` input 4: byte lanes.
- `m0_readdata`, `m1_readdata` output 32: both driven from `s_readdata`; valid only for the granted master at completion.
- `m0_waitrequest`, `m1_waitrequest` output 1: stall to each master.
- `s_address` output 32, `s_read` output 1, `s_write` output 1, `s_writedata` output 32, `s_byteenable` output 4: slave request.
- `s_readdata` input 32, `s_waitrequest` input 1: slave response.
- `grant` output 2: one-hot, bit0 = m0, bit1 = m1, 00 = idle.
- `xfer_count0`, `xfer_count1` output 16: completed transfers per master; wrap 0xFFFF to 0x0000.
- `protocol_error` output 1: sticky until reset.

## Operation
- States: IDLE, GRANT0, GRANT1.
- A master is requesting when `read|write` is high.
- IDLE:
  - No master requesting: stay in IDLE.
  - Exactly one master requesting: go to that master's GRANT state.
  - Both requesting, `FIXED_PRIORITY=1`: go to GRANT0.
  - Both requesting, round-robin: grant the master that is not `last_grant`.
  - `last_grant` resets to 1, so m0 wins the first tie.
- GRANTx:
  - Slave outputs mirror master x combinationally.
  - `mx_waitrequest = s_waitrequest`; the other master's `waitrequest` is 1.
  - Completion is a rising edge with master x requesting and `s_waitrequest=0`. On completion: return to IDLE, set `last_grant=x`, increment `xfer_countx`.
- IDLE: `s_read=s_write=0`, `s_address/s_writedata/s_byteenable=0`, and both `waitrequest=1`.
- Protocol errors set `protocol_error`:
  - Any master asserts `read` and `write` together, in any state.
  - Master x drops its request while in GRANTx without completing. State returns to IDLE on the next edge; the counter is not incremented.
  - While in GRANTx, the forwarded `s_read` and `s_write` are both forced to 0 if master x asserts both.
- Simultaneous completion and new request from the same master: the next request is re-arbitrated from IDLE.

## Timing
- Reset values (edge with `reset=1`): state IDLE, `grant=00`, `last_grant=1`, counters 0, `protocol_error=0`, `s_read=s_write=0`, both `waitrequest=1`.
- Reset mid-transfer: abandon the transfer, go to IDLE next edge, and do not increment the counter.
- Arbitration latency is 1 cycle: a request seen at edge N is forwarded to the slave during cycle N+1.
- Minimum transfer occupancy is 2 cycles (arbitrate + zero-wait slave). One IDLE cycle always separates back-to-back grants.
- `readdata` is combinational from `s_readdata`; the master samples it on the completion edge.
- A granted master must hold address, data and byteenable stable while its `waitrequest=1`.

## Test plan
- Reset, then m0 reads 0xBFC00000 with a 0-wait slave returning 0x12345678:
  - `grant=01` one cycle after the request.
  - `m0_readdata=0x12345678` at the completion edge.
  - `xfer_count0=1`, `grant` returns to 00.
- Both masters request at the same edge, round-robin: m0 is served first, then m1. Both request again: m0 is served, because `last_grant=1`. With `FIXED_PRIORITY=1`, m0 wins every time.
- m1 writes 0xDEADBEEF with byteenable 0xF while the slave holds `s_waitrequest` for 3 cycles:
  - `s_write` stays high for 4 cycles.
  - `m0_waitrequest` stays high throughout.
  - `xfer_count1` increments once.
- m0 asserts `read` and `write` together: `protocol_error=1` and stays set; the slave sees no read or write.
- `reset` asserted during GRANT1 with the slave stalling: IDLE next edge, `s_write=0`, counters 0.
- 65536 m0 transfers: `xfer_count0` wraps to 0x0000 with no error.
